// File: rtl/spi_reg_writer.sv
// spi_reg_writer: oversampled SPI mode-0 target turning host frames into register write strobes
module spi_reg_writer (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        spi_sclk_in,
  input  logic        spi_cs_n_in,
  input  logic        spi_mosi_in,
  output logic [5:0]  addr_out,
  output logic [15:0] data_out,
  output logic        data_valid_out,
  output logic        frame_error_out
);
  typedef enum logic [1:0] {IDLE, HEADER, DATA, DISCARD} state_t;
  state_t      state;
  logic [2:0]  sclk_q, cs_q;
  logic [1:0]  mosi_q;
  logic [3:0]  cnt;
  logic [15:0] sr;
  logic [5:0]  addr;
  logic        inc;
  logic        rise, cs_fall;
  logic [15:0] shifted;
  assign rise    = sclk_q[1] & ~sclk_q[2];
  assign cs_fall = ~cs_q[1] & cs_q[2];
  assign shifted = {sr[14:0], mosi_q[1]};
  // CS_n synchroniser clears low so a select already held at reset release never looks like a fall
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state           <= IDLE;
      sclk_q          <= '0;
      cs_q            <= '0;
      mosi_q          <= '0;
      cnt             <= '0;
      sr              <= '0;
      addr            <= '0;
      inc             <= 1'b0;
      addr_out        <= '0;
      data_out        <= '0;
      data_valid_out  <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      sclk_q          <= {sclk_q[1:0], spi_sclk_in};
      cs_q            <= {cs_q[1:0], spi_cs_n_in};
      mosi_q          <= {mosi_q[0], spi_mosi_in};
      data_valid_out  <= 1'b0;
      frame_error_out <= 1'b0;
      if (cs_q[1]) begin
        frame_error_out <= (state == HEADER || state == DATA) && cnt != 4'd0;
        state           <= IDLE;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            state <= HEADER;
            cnt   <= '0;
            sr    <= '0;
          end
          HEADER: if (rise) begin
            sr  <= shifted;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt   <= '0;
              addr  <= shifted[5:0];
              inc   <= shifted[6];
              state <= shifted[7] ? DATA : DISCARD;
            end
          end
          DATA: if (rise) begin
            sr  <= shifted;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              cnt            <= '0;
              data_out       <= shifted;
              addr_out       <= addr;
              data_valid_out <= 1'b1;
              addr           <= addr + {5'd0, inc};
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
